iter_shifter: RTL and testbench

Multi-cycle sequential shifter with valid/ready handshakes on input and output. It executes the same shift operations as the single-cycle ALU shifter, selected by the same `alufn[1:0]` encoding, and adds rotate-left. Each cycle it shifts by at most STEP bits, trading latency for area. It sits beside the ALU as the low-area shift path and as a golden-result cross-check source for shifter regression.

---
 rtl/iter_shifter.sv | 82 ++++++++
 tb/tb_iter_shifter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shifter (SHL/SHR/SRA/ROL), at most STEP bits per cycle, valid/ready on both sides
module iter_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       alufn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [4:0] STEP_W = 5'(STEP);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [4:0]       rem_q, rem_d;
    logic [1:0]       op_q, op_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [4:0]       s;
    logic [WIDTH-1:0] sra, shifted;
    logic             unused_bits;
    assign unused_bits = ^{alufn[5:2], b[WIDTH-1:5]};
    assign in_ready  = (state_q == IDLE) & rst_n;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign res       = work_q;
    // next-state, one bounded shift step per SHIFT cycle; outputs are precomputed so they leave flops
    always_comb begin
        s = (rem_q < STEP_W) ? rem_q : STEP_W;
        sra = $signed(work_q) >>> s;
        shifted = (op_q == 2'b00) ? work_q << s :
                  (op_q == 2'b01) ? work_q >> s :
                  (op_q == 2'b11) ? sra :
                  (work_q << s) | (work_q >> (6'd32 - {1'b0, s}));
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        op_d    = op_q;
        case (state_q)
            IDLE: if (in_valid && in_ready) begin
                work_d  = a;
                rem_d   = b[4:0];
                op_d    = alufn[1:0];
                state_d = (b[4:0] != 5'd0) ? SHIFT : DONE;
            end
            SHIFT: begin
                work_d  = shifted;
                rem_d   = rem_q - s;
                state_d = (rem_d == 5'd0) ? DONE : SHIFT;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        out_valid_d = state_d == DONE;
        busy_d      = state_d != IDLE;
    end
    // state and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            rem_q       <= '0;
            op_q        <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            rem_q       <= rem_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end
endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: randomized and directed checks of iter_shifter at STEP=1 and STEP=4 against a bitwise model
module tb_iter_shifter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv1 = 1'b0, iv4 = 1'b0, or1 = 1'b1, or4 = 1'b1;
    logic [5:0]  alufn = '0;
    logic [31:0] a = '0, b = '0;
    logic        ir1, ir4, ov1, ov4, busy1, busy4;
    logic [31:0] res1, res4;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    iter_shifter #(.WIDTH(32), .STEP(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .alufn(alufn), .a(a), .b(b),
        .out_valid(ov1), .out_ready(or1), .res(res1), .busy(busy1)
    );
    iter_shifter #(.WIDTH(32), .STEP(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .alufn(alufn), .a(a), .b(b),
        .out_valid(ov4), .out_ready(or4), .res(res4), .busy(busy4)
    );

    // bit-by-bit placement of the operand according to the operation's definition
    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] amt, input logic [5:0] fn);
        int n;
        logic [31:0] r;
        n = int'(amt[4:0]);
        r = '0;
        for (int i = 0; i < 32; i++)
            case (fn[1:0])
                2'b00:   r[i] = (i >= n) ? x[i-n] : 1'b0;
                2'b01:   r[i] = (i + n < 32) ? x[i+n] : 1'b0;
                2'b11:   r[i] = (i + n < 32) ? x[i+n] : x[31];
                default: r[(i + n) % 32] = x[i];
            endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one full transaction with out_ready high; inputs are scrambled every cycle after accept
    task automatic run_op(input bit s4, input logic [31:0] ta, input logic [31:0] tb_, input logic [5:0] fn);
        int step, k, cnt, lat;
        logic [31:0] got, exp;
        step = s4 ? 4 : 1;
        k = (int'(tb_[4:0]) + step - 1) / step;
        exp = model(ta, tb_, fn);
        @(negedge clk);
        chk($sformatf("in_ready s4=%0d", s4), 32'(s4 ? ir4 : ir1), 32'd1);
        a = ta; b = tb_; alufn = fn;
        if (s4) iv4 = 1'b1; else iv1 = 1'b1;
        @(negedge clk);
        iv1 = 1'b0; iv4 = 1'b0;
        cnt = 0; lat = -1; got = 'x;
        while ((s4 ? busy4 : busy1) && cnt < 100) begin
            if ((s4 ? ov4 : ov1) && lat < 0) begin
                lat = cnt;
                got = s4 ? res4 : res1;
            end
            a = $urandom; b = $urandom; alufn = 6'($urandom);
            cnt++;
            @(negedge clk);
        end
        chk($sformatf("latency s4=%0d op=%0d n=%0d", s4, fn[1:0], tb_[4:0]), 32'(lat), 32'(k));
        chk($sformatf("busy_cycles s4=%0d op=%0d n=%0d", s4, fn[1:0], tb_[4:0]), 32'(cnt), 32'(k + 1));
        chk($sformatf("res s4=%0d op=%0d n=%0d a=%h", s4, fn[1:0], tb_[4:0], ta), got, exp);
    endtask

    initial begin
        int cnt;
        logic [31:0] hold;
        repeat (2) @(negedge clk);
        chk("rst in_ready1", 32'(ir1), 32'd0);
        chk("rst in_ready4", 32'(ir4), 32'd0);
        chk("rst out_valid1", 32'(ov1), 32'd0);
        chk("rst busy4", 32'(busy4), 32'd0);
        chk("rst res1", res1, 32'h0);
        chk("rst res4", res4, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst in_ready1", 32'(ir1), 32'd1);
        // directed vectors on both step sizes
        for (int s = 0; s < 2; s++) begin
            run_op(s[0], 32'h87654321, 32'h00000004, 6'h00);
            run_op(s[0], 32'h87654321, 32'h0000001F, 6'h03);
            run_op(s[0], 32'hFEDCBA98, 32'h00000010, 6'h01);
            run_op(s[0], 32'h76543210, 32'h00000009, 6'h03);
            run_op(s[0], 32'h87654321, 32'h00000008, 6'h02);
            run_op(s[0], 32'h87654321, 32'hFFFFFFE0, 6'h3C);
        end
        // every amount for every op, random operands and ignored upper bits
        for (int op = 0; op < 4; op++)
            for (int n = 0; n < 32; n++)
                for (int s = 0; s < 2; s++)
                    run_op(s[0], $urandom, {27'($urandom), 5'(n)}, {4'($urandom), 2'(op)});
        // backpressure: result held, queued request waits until hand-off
        or1 = 1'b0;
        @(negedge clk);
        a = 32'h12345678; b = 32'd3; alufn = 6'h00; iv1 = 1'b1;
        @(negedge clk);
        iv1 = 1'b0;
        cnt = 0;
        while (!ov1 && cnt < 100) begin cnt++; @(negedge clk); end
        chk("bp latency", 32'(cnt), 32'd3);
        hold = res1;
        chk("bp res", hold, model(32'h12345678, 32'd3, 6'h00));
        a = 32'hF0F0F0F0; b = 32'd4; alufn = 6'h01; iv1 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp res stable", res1, hold);
            chk("bp in_ready low", 32'(ir1), 32'd0);
            chk("bp out_valid held", 32'(ov1), 32'd1);
        end
        or1 = 1'b1;
        @(negedge clk);
        chk("bp idle out_valid", 32'(ov1), 32'd0);
        chk("bp idle in_ready", 32'(ir1), 32'd1);
        @(negedge clk);
        iv1 = 1'b0;
        chk("bp queued accepted", 32'(busy1), 32'd1);
        cnt = 0;
        while (!ov1 && cnt < 100) begin cnt++; @(negedge clk); end
        chk("bp queued latency", 32'(cnt), 32'd4);
        chk("bp queued res", res1, model(32'hF0F0F0F0, 32'd4, 6'h01));
        @(negedge clk);
        // asynchronous reset in the middle of a shift
        a = 32'hDEADBEEF; b = 32'd20; alufn = 6'h02; iv1 = 1'b1;
        @(posedge clk);
        #1 iv1 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst busy before", 32'(busy1), 32'd0);
        chk("midrst out_valid", 32'(ov1), 32'd0);
        chk("midrst res", res1, 32'h0);
        chk("midrst in_ready", 32'(ir1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst release in_ready", 32'(ir1), 32'd1);
        run_op(1'b0, 32'h00000001, 32'd31, 6'h00);
        run_op(1'b1, 32'h00000001, 32'd31, 6'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
